// File: rtl/vector_decode_pkg.sv
// vector_decode_pkg: shared encodings and types for the vector issue front end.
//   - opcode, funct3 and funct6 constants for the supported instruction subset
//   - vop_e: compact operation code carried through the issue queue
//   - issue_entry_t: one queued instruction (op, registers, scalar, mask, vl)
// Optional feature macro: VMUL_OPS_EN adds the multiply operations to vop_e.
package vector_decode_pkg;

    localparam logic [6:0] OPC_ARITH = 7'b1010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPIVI = 3'b011;
    localparam logic [2:0] F3_OPIVX = 3'b100;
    localparam logic [2:0] F3_OPMVX = 3'b110;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    localparam logic [5:0] F6_ADD    = 6'b000000;
    localparam logic [5:0] F6_SUB    = 6'b000010;
    localparam logic [5:0] F6_MINU   = 6'b000100;
    localparam logic [5:0] F6_MIN    = 6'b000101;
    localparam logic [5:0] F6_AND    = 6'b001001;
    localparam logic [5:0] F6_OR     = 6'b001010;
    localparam logic [5:0] F6_XOR    = 6'b001011;
    localparam logic [5:0] F6_MERGE  = 6'b010111;
    localparam logic [5:0] F6_MSEQ   = 6'b011000;
    localparam logic [5:0] F6_MSNE   = 6'b011001;
    localparam logic [5:0] F6_MSLTU  = 6'b011010;
    localparam logic [5:0] F6_MSLT   = 6'b011011;
    localparam logic [5:0] F6_MSLEU  = 6'b011100;
    localparam logic [5:0] F6_MSLE   = 6'b011101;
    localparam logic [5:0] F6_MSGTU  = 6'b011110;
    localparam logic [5:0] F6_MSGT   = 6'b011111;
    localparam logic [5:0] F6_SHLL   = 6'b100101;
    localparam logic [5:0] F6_SHRL   = 6'b101000;
    localparam logic [5:0] F6_SHRA   = 6'b101001;
    // Multiply codes live in the OPMVV/OPMVX space; 100101 overlaps F6_SHLL.
    localparam logic [5:0] F6_MULHU  = 6'b100100;
    localparam logic [5:0] F6_MUL    = 6'b100101;
    localparam logic [5:0] F6_MULHSU = 6'b100110;
    localparam logic [5:0] F6_MULHS  = 6'b100111;

    // Storage width of the vl snapshot; the top narrows it to its own VL_W.
    localparam int unsigned ENTRY_VL_W = 16;

    // VOP_ADD must stay first so a cleared entry reads as op 0.
    typedef enum logic [4:0] {
        VOP_ADD, VOP_SUB, VOP_AND, VOP_OR, VOP_XOR, VOP_MERGE, VOP_MINU, VOP_MIN,
        VOP_SHLL, VOP_SHRL, VOP_SHRA,
        VOP_MSEQ, VOP_MSNE, VOP_MSLTU, VOP_MSLT, VOP_MSLEU, VOP_MSLE, VOP_MSGTU, VOP_MSGT,
        VOP_LOAD, VOP_STORE
`ifdef VMUL_OPS_EN
        , VOP_MUL, VOP_MULHSU, VOP_MULHS, VOP_MULHU
`endif
    } vop_e;

    typedef struct packed {
        vop_e                  op;
        logic [4:0]            vd;
        logic [4:0]            vs1;
        logic [4:0]            vs2;
        logic [31:0]           scalar;
        logic                  vm;
        logic [ENTRY_VL_W-1:0] vl;
    } issue_entry_t;

endpackage

// File: rtl/vector_instr_decoder.sv
// vector_instr_decoder: combinational classifier for one raw vector instruction.
//   instr    in  32  raw instruction
//   rs1_data in  32  scalar rs1 value (OPIVX/OPMVX operand, vsetvli AVL)
//   vl       in  16  current vl, copied into the entry as a snapshot
//   legal    out 1   instruction is recognised (includes vsetvli)
//   is_cfg   out 1   instruction is a configuration update, never queued
//   entry    out     decoded queue entry
// Optional feature macro: VMUL_OPS_EN enables the OPMVV/OPMVX multiply decode.
module vector_instr_decoder
    import vector_decode_pkg::*;
(
    input  logic [31:0]           instr,
    input  logic [31:0]           rs1_data,
    input  logic [ENTRY_VL_W-1:0] vl,
    output logic                  legal,
    output logic                  is_cfg,
    output issue_entry_t          entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] funct6;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct6 = instr[31:26];

    always_comb begin
        legal        = 1'b0;
        is_cfg       = 1'b0;
        entry.op     = VOP_ADD;
        entry.vd     = instr[11:7];
        entry.vs1    = instr[19:15];
        entry.vs2    = instr[24:20];
        entry.scalar = '0;
        entry.vm     = instr[25];
        entry.vl     = vl;

        case (opcode)
            OPC_ARITH: begin
                case (funct3)
                    F3_OPIVV, F3_OPIVX, F3_OPIVI: begin
                        legal = 1'b1;
                        if (funct3 == F3_OPIVX) begin
                            entry.scalar = rs1_data;
                        end else if (funct3 == F3_OPIVI) begin
                            entry.scalar = {{27{instr[19]}}, instr[19:15]};
                        end
                        case (funct6)
                            F6_ADD:   entry.op = VOP_ADD;
                            F6_SUB:   entry.op = VOP_SUB;
                            F6_AND:   entry.op = VOP_AND;
                            F6_OR:    entry.op = VOP_OR;
                            F6_XOR:   entry.op = VOP_XOR;
                            F6_MERGE: entry.op = VOP_MERGE;
                            F6_MINU:  entry.op = VOP_MINU;
                            F6_MIN:   entry.op = VOP_MIN;
                            F6_SHLL:  entry.op = VOP_SHLL;
                            F6_SHRL:  entry.op = VOP_SHRL;
                            F6_SHRA:  entry.op = VOP_SHRA;
                            F6_MSEQ:  entry.op = VOP_MSEQ;
                            F6_MSNE:  entry.op = VOP_MSNE;
                            F6_MSLTU: entry.op = VOP_MSLTU;
                            F6_MSLT:  entry.op = VOP_MSLT;
                            F6_MSLEU: entry.op = VOP_MSLEU;
                            F6_MSLE:  entry.op = VOP_MSLE;
                            F6_MSGTU: entry.op = VOP_MSGTU;
                            F6_MSGT:  entry.op = VOP_MSGT;
                            default:  legal    = 1'b0;
                        endcase
                    end
                    F3_OPMVV, F3_OPMVX: begin
`ifdef VMUL_OPS_EN
                        legal = 1'b1;
                        if (funct3 == F3_OPMVX) begin
                            entry.scalar = rs1_data;
                        end
                        case (funct6)
                            F6_MUL:    entry.op = VOP_MUL;
                            F6_MULHSU: entry.op = VOP_MULHSU;
                            F6_MULHS:  entry.op = VOP_MULHS;
                            F6_MULHU:  entry.op = VOP_MULHU;
                            default:   legal    = 1'b0;
                        endcase
`else
                        legal = 1'b0;
`endif
                    end
                    F3_OPCFG: begin
                        legal  = 1'b1;
                        is_cfg = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                // Only unit-stride (mop == 00) is supported.
                legal    = (instr[27:26] == 2'b00);
                entry.op = (opcode == OPC_LOAD) ? VOP_LOAD : VOP_STORE;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/vector_issue_queue.sv
// vector_issue_queue: decode, vsetvli tracking and in-order issue FIFO.
//   clk, reset (async, active-low)
//   instr_i, rs1_data_i, instr_valid_i / instr_ready_o    input handshake
//   issue_valid_o / issue_ready_i, issue_op_o, issue_vd_o, issue_vs1_o, issue_vs2_o,
//   issue_scalar_o, issue_vm_o, issue_vl_o                 output handshake (head entry)
//   vl_o, sew_o                                            current configuration
//   illegal_o                                              one-cycle pulse on a rejected instruction
//   count_o                                                queue occupancy
// Optional feature macro: VMUL_OPS_EN (multiply decode, see vector_instr_decoder).
module vector_issue_queue
    import vector_decode_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MAX_VL = 64,
    parameter int unsigned VL_W   = $clog2(MAX_VL + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instr_i,
    input  logic [31:0]                 rs1_data_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    output logic                        issue_valid_o,
    input  logic                        issue_ready_i,
    output logic [$bits(vop_e)-1:0]     issue_op_o,
    output logic [4:0]                  issue_vd_o,
    output logic [4:0]                  issue_vs1_o,
    output logic [4:0]                  issue_vs2_o,
    output logic [31:0]                 issue_scalar_o,
    output logic                        issue_vm_o,
    output logic [VL_W-1:0]             issue_vl_o,
    output logic [VL_W-1:0]             vl_o,
    output logic [2:0]                  sew_o,
    output logic                        illegal_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    issue_entry_t       mem_q [DEPTH];
    issue_entry_t       dec_entry;
    issue_entry_t       head;
    logic               dec_legal;
    logic               dec_is_cfg;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [VL_W-1:0]    vl_q, vl_d, cfg_vl;
    logic [2:0]         sew_q, sew_d;
    logic               illegal_q, illegal_d;
    logic               accept, push, pop;
    logic               unused_vl;

    vector_instr_decoder u_decoder (
        .instr    (instr_i),
        .rs1_data (rs1_data_i),
        .vl       (ENTRY_VL_W'(vl_q)),
        .legal    (dec_legal),
        .is_cfg   (dec_is_cfg),
        .entry    (dec_entry)
    );

    // Ready depends only on the registered count: a pop never frees space in the same cycle.
    assign instr_ready_o = (count_q < CNT_W'(DEPTH));
    assign issue_valid_o = (count_q != '0);
    assign accept        = instr_valid_i && instr_ready_o;
    assign push          = accept && dec_legal && !dec_is_cfg;
    assign pop           = issue_valid_o && issue_ready_i;

    assign cfg_vl = (rs1_data_i > 32'(MAX_VL)) ? VL_W'(MAX_VL) : VL_W'(rs1_data_i);

    always_comb begin
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        vl_d      = vl_q;
        sew_d     = sew_q;
        illegal_d = accept && !dec_legal;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept && dec_is_cfg) begin
            vl_d  = cfg_vl;
            sew_d = instr_i[25:23];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            vl_q      <= '0;
            sew_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            vl_q      <= vl_d;
            sew_q     <= sew_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage is cleared too so the issue outputs read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= dec_entry;
        end
    end

    assign head           = mem_q[rptr_q];
    assign issue_op_o     = head.op;
    assign issue_vd_o     = head.vd;
    assign issue_vs1_o    = head.vs1;
    assign issue_vs2_o    = head.vs2;
    assign issue_scalar_o = head.scalar;
    assign issue_vm_o     = head.vm;
    assign issue_vl_o     = VL_W'(head.vl);
    // Snapshot bits above VL_W are always zero.
    assign unused_vl      = ^(head.vl >> VL_W);

    assign vl_o      = vl_q;
    assign sew_o     = sew_q;
    assign illegal_o = illegal_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_vector_issue_queue.sv
module tb_vector_issue_queue;
    import vector_decode_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] instr_i;
    logic [31:0] rs1_data_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [$bits(vop_e)-1:0] issue_op_o;
    logic [4:0]  issue_vd_o, issue_vs1_o, issue_vs2_o;
    logic [31:0] issue_scalar_o;
    logic        issue_vm_o;
    logic [6:0]  issue_vl_o;
    logic [6:0]  vl_o;
    logic [2:0]  sew_o;
    logic        illegal_o;
    logic [2:0]  count_o;

    int checks = 0;
    int failures = 0;
    int exp_vl = 0;
    issue_entry_t exp_q[$];
    issue_entry_t dummy;
    logic [31:0]  cfg;
    logic [31:0]  ins;
    logic [5:0]   bp_f6 [4];
    vop_e         bp_op [4];

    vector_issue_queue dut (
        .clk            (clk),
        .reset          (reset),
        .instr_i        (instr_i),
        .rs1_data_i     (rs1_data_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .issue_op_o     (issue_op_o),
        .issue_vd_o     (issue_vd_o),
        .issue_vs1_o    (issue_vs1_o),
        .issue_vs2_o    (issue_vs2_o),
        .issue_scalar_o (issue_scalar_o),
        .issue_vm_o     (issue_vm_o),
        .issue_vl_o     (issue_vl_o),
        .vl_o           (vl_o),
        .sew_o          (sew_o),
        .illegal_o      (illegal_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] arith(input logic [5:0] f6, input logic vm,
                                          input logic [4:0] vs2, input logic [4:0] vs1,
                                          input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic issue_entry_t ent(input vop_e op, input logic [4:0] vd,
                                         input logic [4:0] vs1, input logic [4:0] vs2,
                                         input logic [31:0] sc, input logic vm);
        issue_entry_t e;
        e.op = op; e.vd = vd; e.vs1 = vs1; e.vs2 = vs2;
        e.scalar = sc; e.vm = vm; e.vl = 16'(exp_vl);
        return e;
    endfunction

    // Drive one instruction, wait (bounded) for ready, then let one edge accept it.
    task automatic send(input logic [31:0] i, input logic [31:0] rs1, input bit do_push,
                        input issue_entry_t e);
        int n;
        n = 0;
        instr_i = i;
        rs1_data_i = rs1;
        instr_valid_i = 1'b1;
        while (!instr_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", 32'(instr_ready_o), 32'd1);
        if (do_push) exp_q.push_back(e);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (count_o != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_scoreboard_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every handshake on the issue side pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (reset && issue_valid_o && issue_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(issue_valid_o), 32'd0);
            end else begin
                issue_entry_t e;
                e = exp_q.pop_front();
                chk("iss_op", 32'(issue_op_o), 32'(e.op));
                chk("iss_vd", 32'(issue_vd_o), 32'(e.vd));
                chk("iss_vs1", 32'(issue_vs1_o), 32'(e.vs1));
                chk("iss_vs2", 32'(issue_vs2_o), 32'(e.vs2));
                chk("iss_scalar", issue_scalar_o, e.scalar);
                chk("iss_vm", 32'(issue_vm_o), 32'(e.vm));
                chk("iss_vl", 32'(issue_vl_o), 32'(e.vl));
            end
        end
    end

    initial begin
        clk = 0; reset = 0; instr_i = 0; rs1_data_i = 0; instr_valid_i = 0; issue_ready_i = 0;
        dummy = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_vl", 32'(vl_o), 32'd0);
        chk("rst_sew", 32'(sew_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        chk("rst_op", 32'(issue_op_o), 32'd0);
        chk("rst_scalar", issue_scalar_o, 32'd0);
        reset = 1;
        @(posedge clk); #1;
        issue_ready_i = 1;

        // OPIVV add into an empty queue: visible right after the accepting edge.
        send(arith(6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 32'h12345678, 1'b1,
             ent(VOP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1));
        chk("t1_valid", 32'(issue_valid_o), 32'd1);
        chk("t1_count", 32'(count_o), 32'd1);
        chk("t1_op", 32'(issue_op_o), 32'(VOP_ADD));
        chk("t1_vl", 32'(issue_vl_o), 32'd0);
        @(posedge clk); #1;
        chk("t1_empty", 32'(issue_valid_o), 32'd0);

        // vsetvli with AVL 100 clamps to 64, sew field 010.
        cfg = 32'd0;
        cfg[6:0] = 7'b1010111; cfg[14:12] = 3'b111; cfg[25:23] = 3'b010;
        cfg[19:15] = 5'd9; cfg[11:7] = 5'd1;
        send(cfg, 32'd100, 1'b0, dummy);
        exp_vl = 64;
        chk("cfg_vl", 32'(vl_o), 32'd64);
        chk("cfg_sew", 32'(sew_o), 32'd2);
        chk("cfg_not_queued", 32'(count_o), 32'd0);
        chk("cfg_no_illegal", 32'(illegal_o), 32'd0);
        send(arith(6'b000010, 1'b1, 5'd4, 5'd7, 3'b100, 5'd5), 32'hDEADBEEF, 1'b1,
             ent(VOP_SUB, 5'd5, 5'd7, 5'd4, 32'hDEADBEEF, 1'b1));
        chk("t2_count", 32'(count_o), 32'd1);
        @(posedge clk); #1;
        chk("t2_count_after", 32'(count_o), 32'd0);

        // AVL below the maximum is taken as-is.
        cfg[25:23] = 3'b011;
        send(cfg, 32'd10, 1'b0, dummy);
        exp_vl = 10;
        chk("cfg2_vl", 32'(vl_o), 32'd10);
        chk("cfg2_sew", 32'(sew_o), 32'd3);

        // Backpressure: fill the queue, then a pop releases the fifth.
        issue_ready_i = 0;
        bp_f6[0] = 6'b001001; bp_op[0] = VOP_AND;
        bp_f6[1] = 6'b001010; bp_op[1] = VOP_OR;
        bp_f6[2] = 6'b001011; bp_op[2] = VOP_XOR;
        bp_f6[3] = 6'b000100; bp_op[3] = VOP_MINU;
        for (int i = 0; i < 4; i++) begin
            send(arith(bp_f6[i], 1'b0, 5'(i + 10), 5'(i + 20), 3'b000, 5'(i + 1)), 32'd0, 1'b1,
                 ent(bp_op[i], 5'(i + 1), 5'(i + 20), 5'(i + 10), 32'd0, 1'b0));
        end
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(instr_ready_o), 32'd0);
        chk("full_head_vd", 32'(issue_vd_o), 32'd1);
        @(posedge clk); #1;
        chk("stall_vd", 32'(issue_vd_o), 32'd1);
        chk("stall_op", 32'(issue_op_o), 32'(VOP_AND));
        ins = arith(6'b000101, 1'b1, 5'd30, 5'd31, 3'b000, 5'd5);
        instr_i = ins; instr_valid_i = 1;
        issue_ready_i = 1;
        chk("full_pop_ready_low", 32'(instr_ready_o), 32'd0);
        send(ins, 32'd0, 1'b1, ent(VOP_MIN, 5'd5, 5'd31, 5'd30, 32'd0, 1'b1));
        chk("push_pop_count", 32'(count_o), 32'd3);
        drain();

        // funct6 100101 is a shift under OPIVV and a multiply under OPMVV.
        send(arith(6'b100101, 1'b1, 5'd6, 5'd8, 3'b000, 5'd9), 32'd0, 1'b1,
             ent(VOP_SHLL, 5'd9, 5'd8, 5'd6, 32'd0, 1'b1));
        @(posedge clk); #1;
`ifdef VMUL_OPS_EN
        send(arith(6'b100101, 1'b1, 5'd6, 5'd8, 3'b010, 5'd10), 32'd0, 1'b1,
             ent(VOP_MUL, 5'd10, 5'd8, 5'd6, 32'd0, 1'b1));
        chk("mul_legal", 32'(illegal_o), 32'd0);
`else
        send(arith(6'b100101, 1'b1, 5'd6, 5'd8, 3'b010, 5'd10), 32'd0, 1'b0, dummy);
        chk("mul_illegal", 32'(illegal_o), 32'd1);
        chk("mul_count", 32'(count_o), 32'd0);
        @(posedge clk); #1;
        chk("illegal_pulse_end", 32'(illegal_o), 32'd0);
`endif
        drain();

        // OPIVI sign-extends imm5.
        send(arith(6'b000000, 1'b1, 5'd3, 5'b10000, 3'b011, 5'd11), 32'hCAFE0000, 1'b1,
             ent(VOP_ADD, 5'd11, 5'b10000, 5'd3, 32'hFFFFFFF0, 1'b1));
        // Strided load is rejected.
        send({3'b000, 1'b0, 2'b10, 1'b1, 5'd4, 5'd2, 3'b110, 5'd12, 7'b0000111}, 32'd0,
             1'b0, dummy);
        chk("strided_illegal", 32'(illegal_o), 32'd1);
        send({3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd2, 3'b110, 5'd12, 7'b0000111}, 32'h1000,
             1'b1, ent(VOP_LOAD, 5'd12, 5'd2, 5'd0, 32'd0, 1'b1));
        chk("load_legal", 32'(illegal_o), 32'd0);
        send({3'b000, 1'b0, 2'b00, 1'b0, 5'd0, 5'd3, 3'b110, 5'd13, 7'b0100111}, 32'h2000,
             1'b1, ent(VOP_STORE, 5'd13, 5'd3, 5'd0, 32'd0, 1'b0));
        send(arith(6'b111111, 1'b1, 5'd1, 5'd1, 3'b000, 5'd1), 32'd0, 1'b0, dummy);
        chk("bad_funct6_illegal", 32'(illegal_o), 32'd1);
        send(arith(6'b000000, 1'b1, 5'd1, 5'd1, 3'b001, 5'd1), 32'd0, 1'b0, dummy);
        chk("opfvv_illegal", 32'(illegal_o), 32'd1);
        drain();

        // Asynchronous reset with three entries queued.
        issue_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            send(arith(6'b001010, 1'b1, 5'd1, 5'd2, 3'b000, 5'(i + 1)), 32'd0, 1'b1,
                 ent(VOP_OR, 5'(i + 1), 5'd2, 5'd1, 32'd0, 1'b1));
        end
        chk("pre_rst_count", 32'(count_o), 32'd3);
        chk("pre_rst_vl", 32'(vl_o), 32'd10);
        #2;
        reset = 0;
        #1;
        chk("async_rst_count", 32'(count_o), 32'd0);
        chk("async_rst_valid", 32'(issue_valid_o), 32'd0);
        chk("async_rst_vl", 32'(vl_o), 32'd0);
        chk("async_rst_ready", 32'(instr_ready_o), 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("post_rst_count", 32'(count_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
